// File: rtl/instr_mem_responder.sv
// instr_mem_responder: pipelined instruction memory responder with credit flow control, flush and program-load port.
// Define IMEM_ALIGN_CHECK_EN to fault fetch addresses that are not word aligned.
module instr_mem_responder #(
  parameter int DEPTH      = 64,
  parameter int LATENCY    = 2,
  parameter int RESP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_instr,
  output logic        resp_fault,
  input  logic        resp_ready,
  input  logic        flush,
  input  logic        load_en,
  input  logic [63:0] load_addr,
  input  logic [31:0] load_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP = 32'hD503201F;

  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   r_fd [2**PW];
  logic          r_ff [2**PW];
  logic [PW:0]   r_wp;
  logic [PW:0]   r_rp;
  logic [CW-1:0] r_out;
  logic          w_acc;
  logic          w_take;
  logic          w_empty;
  logic          w_fault;
  logic          w_load_ok;
  logic [31:0]   w_word;
  logic          w_tail_v;
  logic [31:0]   w_tail_d;
  logic          w_tail_f;
  logic [PW-1:0] w_wi;
  logic          w_unused;

  assign w_unused  = ^{load_addr[1:0], req_addr[1:0]};
  assign w_acc     = req_valid && req_ready;
  assign w_take    = resp_valid && resp_ready;
  assign w_load_ok = load_en && ~|load_addr[63:AW+2];
`ifdef IMEM_ALIGN_CHECK_EN
  assign w_fault   = (|req_addr[63:AW+2]) || (|req_addr[1:0]);
`else
  assign w_fault   = |req_addr[63:AW+2];
`endif
  // Non-blocking write below means a same-edge fetch of the loaded word sees the old contents.
  assign w_word    = w_fault ? NOP : r_mem[req_addr[AW+1:2]];

  always_ff @(posedge clk)
    if (w_load_ok) r_mem[load_addr[AW+1:2]] <= load_data;

  generate
    if (LATENCY == 1) begin : g_direct
      assign w_tail_v = w_acc;
      assign w_tail_d = w_word;
      assign w_tail_f = w_fault;
    end else begin : g_pipe
      logic        r_pv [LATENCY-1];
      logic [31:0] r_pd [LATENCY-1];
      logic        r_pf [LATENCY-1];
      always_ff @(posedge clk or negedge reset)
        if (!reset) begin
          for (int i = 0; i < LATENCY-1; i++) r_pv[i] <= 1'b0;
        end else begin
          r_pv[0] <= w_acc;
          for (int i = 1; i < LATENCY-1; i++) r_pv[i] <= r_pv[i-1] && !flush;
        end
      always_ff @(posedge clk) begin
        r_pd[0] <= w_word;
        r_pf[0] <= w_fault;
        for (int i = 1; i < LATENCY-1; i++) begin
          r_pd[i] <= r_pd[i-1];
          r_pf[i] <= r_pf[i-1];
        end
      end
      assign w_tail_v = r_pv[LATENCY-2] && !flush;
      assign w_tail_d = r_pd[LATENCY-2];
      assign w_tail_f = r_pf[LATENCY-2];
    end
  endgenerate

  // A flush restarts the FIFO at slot 0 so a surviving write lands there.
  assign w_wi    = flush ? '0 : r_wp[PW-1:0];
  assign w_empty = r_wp == r_rp;

  always_ff @(posedge clk)
    if (w_tail_v) begin
      r_fd[w_wi] <= w_tail_d;
      r_ff[w_wi] <= w_tail_f;
    end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_out <= '0;
    end else if (flush) begin
      r_wp  <= {{PW{1'b0}}, w_tail_v};
      r_rp  <= '0;
      r_out <= {{PW{1'b0}}, w_acc};
    end else begin
      r_wp  <= r_wp + {{PW{1'b0}}, w_tail_v};
      r_rp  <= r_rp + {{PW{1'b0}}, w_take};
      r_out <= r_out + {{PW{1'b0}}, w_acc} - {{PW{1'b0}}, w_take};
    end

  assign req_ready  = reset && (r_out < CW'(RESP_DEPTH));
  assign resp_valid = !w_empty;
  assign resp_instr = w_empty ? 32'h0 : r_fd[r_rp[PW-1:0]];
  assign resp_fault = w_empty ? 1'b0 : r_ff[r_rp[PW-1:0]];
endmodule

// File: tb/tb_instr_mem_responder.sv
// tb_instr_mem_responder: constant-vector table, directed corner sequences and a random run against a queue-based model.
module tb_instr_mem_responder;
  localparam int DEPTH = 64;
  localparam int LAT   = 2;
  localparam int RD    = 4;
  localparam logic [31:0] NOP = 32'hD503201F;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [63:0] req_addr = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_instr;
  logic        resp_fault;
  logic        resp_ready = 1'b0;
  logic        flush = 1'b0;
  logic        load_en = 1'b0;
  logic [63:0] load_addr = '0;
  logic [31:0] load_data = '0;

  instr_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .RESP_DEPTH(RD)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_instr(resp_instr), .resp_fault(resp_fault), .resp_ready(resp_ready),
    .flush(flush), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] instr; logic fault; int vis; } resp_t;
  typedef struct { logic [63:0] addr; logic [31:0] instr; logic fault; } vec_t;

  resp_t       q[$];
  logic [31:0] m_mem [DEPTH];
  logic [31:0] got_i[$];
  logic        got_f[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          dut_acc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic m_ready();
    return q.size() < RD;
  endfunction

  function automatic logic m_valid();
    return q.size() > 0 && q[0].vis <= cyc;
  endfunction

  function automatic resp_t m_fetch(input logic [63:0] a);
    resp_t r;
    r.fault = a >= 64'(DEPTH * 4);
`ifdef IMEM_ALIGN_CHECK_EN
    r.fault = r.fault || (a[1:0] != 2'b00);
`endif
    r.instr = r.fault ? NOP : m_mem[a[7:2]];
    r.vis = 0;
    return r;
  endfunction

  task automatic stepl(input logic rv, input logic [63:0] ra, input logic rr, input logic fl,
                       input logic le, input logic [63:0] la, input logic [31:0] ld);
    logic acc, take;
    resp_t r;
    req_valid = rv; req_addr = ra; resp_ready = rr; flush = fl;
    load_en = le; load_addr = la; load_data = ld;
    #1;
    check("req_ready", 32'(req_ready), 32'(m_ready()));
    check("resp_valid", 32'(resp_valid), 32'(m_valid()));
    if (m_valid() && resp_valid) begin
      check("resp_instr", resp_instr, q[0].instr);
      check("resp_fault", 32'(resp_fault), 32'(q[0].fault));
    end
    if (req_valid && req_ready) dut_acc++;
    if (resp_valid && resp_ready) begin
      got_i.push_back(resp_instr);
      got_f.push_back(resp_fault);
    end
    acc = rv && m_ready();
    take = m_valid() && rr;
    r = m_fetch(ra);
    @(posedge clk);
    cyc++;
    if (take) void'(q.pop_front());
    if (fl) q.delete();
    if (acc) begin
      r.vis = cyc + LAT - 1;
      q.push_back(r);
    end
    if (le && la < 64'(DEPTH * 4)) m_mem[la[7:2]] = ld;
    #1;
  endtask

  task automatic step(input logic rv, input logic [63:0] ra, input logic rr, input logic fl);
    stepl(rv, ra, rr, fl, 1'b0, 64'h0, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 64'h0, 1'b1, 1'b0);
  endtask

  task automatic clear_log();
    got_i.delete();
    got_f.delete();
  endtask

  function automatic logic [31:0] got_at(input int k);
    return (k < got_i.size()) ? got_i[k] : 32'hxxxxxxxx;
  endfunction

  vec_t        vecs [9];
  logic [31:0] w0 [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    w0[0] = 32'h8B020020; w0[1] = 32'hCB030041; w0[2] = 32'hF8400062; w0[3] = 32'hB4000043;
    vecs[0] = '{64'd0,   32'h8B020020, 1'b0};
    vecs[1] = '{64'd4,   32'hCB030041, 1'b0};
    vecs[2] = '{64'd8,   32'hF8400062, 1'b0};
    vecs[3] = '{64'd12,  32'hB4000043, 1'b0};
    vecs[4] = '{64'd256, NOP,          1'b1};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFC, NOP, 1'b1};
    vecs[6] = '{64'd252, 32'h0BADF00D, 1'b0};
`ifdef IMEM_ALIGN_CHECK_EN
    vecs[7] = '{64'd6,   NOP,          1'b1};
    vecs[8] = '{64'd253, NOP,          1'b1};
`else
    vecs[7] = '{64'd6,   32'hCB030041, 1'b0};
    vecs[8] = '{64'd253, 32'h0BADF00D, 1'b0};
`endif

    #2;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_instr", resp_instr, 32'h0);
    check("rst_resp_fault", 32'(resp_fault), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < DEPTH; i++)
      stepl(1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 64'(i * 4),
            i < 4 ? w0[i] : (i == DEPTH - 1 ? 32'h0BADF00D : $urandom));
    stepl(1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 64'd256, 32'hDEADBEEF);

    for (int v = 0; v < 9; v++) begin
      clear_log();
      step(1'b1, vecs[v].addr, 1'b1, 1'b0);
      idle(LAT + 1);
      check($sformatf("vec%0d_count", v), 32'(got_i.size()), 32'd1);
      check($sformatf("vec%0d_instr", v), got_at(0), vecs[v].instr);
      check($sformatf("vec%0d_fault", v), 32'(got_f.size() > 0 ? got_f[0] : 1'bx), 32'(vecs[v].fault));
    end

    clear_log();
    for (int i = 0; i < 4; i++) step(1'b1, 64'(i * 4), 1'b1, 1'b0);
    idle(LAT + 2);
    check("b2b_count", 32'(got_i.size()), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("b2b_word%0d", i), got_at(i), w0[i]);

    clear_log();
    dut_acc = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 64'(i * 4), 1'b0, 1'b0);
    check("bp_accepts", 32'(dut_acc), 32'd4);
    check("bp_ready_low", 32'(req_ready), 32'h0);
    idle(6);
    check("bp_count", 32'(got_i.size()), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("bp_word%0d", i), got_at(i), w0[i]);
    check("bp_ready_back", 32'(req_ready), 32'h1);

    clear_log();
    step(1'b1, 64'd0, 1'b0, 1'b0);
    step(1'b1, 64'd4, 1'b0, 1'b0);
    step(1'b1, 64'd8, 1'b0, 1'b0);
    step(1'b1, 64'd12, 1'b0, 1'b1);
    idle(LAT + 2);
    check("flush_count", 32'(got_i.size()), 32'd1);
    check("flush_word", got_at(0), w0[3]);

    clear_log();
    stepl(1'b1, 64'd4, 1'b1, 1'b0, 1'b1, 64'd4, 32'h12345678);
    idle(LAT + 1);
    step(1'b1, 64'd4, 1'b1, 1'b0);
    idle(LAT + 1);
    check("rw_old", got_at(0), 32'hCB030041);
    check("rw_new", got_at(1), 32'h12345678);

    clear_log();
    for (int i = 0; i < 3; i++) step(1'b1, 64'(i * 4), 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("arst_resp_valid", 32'(resp_valid), 32'h0);
    check("arst_req_ready", 32'(req_ready), 32'h0);
    q.delete();
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(2);
    check("arst_stale", 32'(got_i.size()), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 64'(i * 4), 1'b1, 1'b0);
    idle(LAT + 2);
    check("arst_mem0", got_at(0), w0[0]);
    check("arst_mem1", got_at(1), 32'h12345678);
    check("arst_mem2", got_at(2), w0[2]);
    check("arst_mem3", got_at(3), w0[3]);

    for (int n = 0; n < 500; n++) begin
      logic [63:0] a;
      int sel;
      sel = $urandom_range(0, 9);
      a = (sel == 0) ? 64'($urandom_range(64, 200)) * 4 + 64'($urandom_range(0, 3)) :
          (sel == 1) ? 64'($urandom_range(0, 255)) : 64'($urandom_range(0, 63)) * 4;
      stepl($urandom_range(0, 3) != 0, a, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 7) == 0, 64'($urandom_range(0, 300)), $urandom);
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
